// File: rtl/product_serializer_pkg.sv
// ============================================================================
// Module  : product_serializer_pkg
// Purpose : Shared types and constants for the product word serializer.
//           Holds the state encoding, the ASCII line terminator bytes and
//           helpers that size a frame from the product word width.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package product_serializer_pkg;

  // TERM is only reachable when the hex/ASCII framing is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Raw framing: bytes needed to carry a w-bit word.
  function automatic int calc_nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  // Hex framing: hex characters needed to carry a w-bit word.
  function automatic int calc_nhex(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_to_ascii.sv
// ============================================================================
// Module  : nibble_to_ascii
// Purpose : Combinational conversion of one 4-bit value to its uppercase
//           ASCII hex character ('0'-'9', 'A'-'F').
// Ports   : nibble  in   4  value to convert
//           ascii   out  8  ASCII character code
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 'A' is 0x41, so values 10..15 map through an offset of 0x37.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

`default_nettype wire

// File: rtl/product_serializer.sv
// ============================================================================
// Module  : product_serializer
// Purpose : Accepts one product word over a valid/ready handshake and emits
//           it as a byte stream over a second valid/ready handshake. A frame
//           is fully drained before the next word is accepted.
//           Default build: raw binary, (DATA_W+7)/8 bytes, LSB byte first.
//           With PRODUCT_SERIALIZER_HEX_EN defined: (DATA_W+3)/4 uppercase
//           ASCII hex characters, MSB nibble first, followed by CR, LF.
// Ports   : clk        in   1       system clock, rising edge
//           rst        in   1       asynchronous active-low reset
//           in_data    in   DATA_W  product word
//           in_valid   in   1       in_data is valid
//           in_ready   out  1       block can accept a word (combinational)
//           out_data   out  8       current byte
//           out_valid  out  1       out_data is valid
//           out_ready  in   1       downstream accepts the byte
//           busy       out  1       a frame is in progress
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module product_serializer
  import product_serializer_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

`ifdef PRODUCT_SERIALIZER_HEX_EN
  localparam int NHEX   = calc_nhex(DATA_W);
  localparam int SR_W   = 4 * NHEX;
  localparam int NFRAME = NHEX + 2;  // characters plus CR, LF
`else
  localparam int NBYTES = calc_nbytes(DATA_W);
  localparam int SR_W   = 8 * NBYTES;
  localparam int NFRAME = NBYTES;
`endif
  localparam int CNT_W  = $clog2(NFRAME + 1);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              xfer;

  // Held low during reset so nothing is accepted while flops are cleared.
  assign in_ready = (state_q == IDLE) && rst;
  assign xfer     = out_valid_q && out_ready;

`ifdef PRODUCT_SERIALIZER_HEX_EN
  logic [7:0] hex_char;

  // Converts the nibble that will be on the wire after this edge, so the
  // output byte can be registered together with the shift register.
  nibble_to_ascii u_nibble_to_ascii (
    .nibble (sr_d[SR_W-1 -: 4]),
    .ascii  (hex_char)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sr_d    = SR_W'(in_data);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          sr_d  = sr_q << 4;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NHEX - 1)) begin
            state_d = TERM;
          end
        end
      end
      TERM: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NFRAME - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d = 8'h00;
    unique case (state_d)
      SEND:    out_data_d = hex_char;
      TERM:    out_data_d = (cnt_d == CNT_W'(NHEX)) ? ASCII_CR : ASCII_LF;
      default: out_data_d = 8'h00;
    endcase
  end
`else
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sr_d    = SR_W'(in_data);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          sr_d  = sr_q >> 8;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NFRAME - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d = (state_d == SEND) ? sr_d[7:0] : 8'h00;
  end
`endif

  // Any non-idle state is a frame in flight with a byte on offer.
  always_comb begin
    out_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_product_serializer.sv
// ============================================================================
// Module  : tb_product_serializer
// Purpose : Directed self-checking bench for product_serializer. Expected
//           byte streams are hand-written tables; the hex tables are used when
//           PRODUCT_SERIALIZER_HEX_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_product_serializer;

  logic        clk;
  logic        rst;
  logic [35:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_vec;
  int n_err;

  logic [7:0] exp_b [0:15];
  int         exp_n;

  product_serializer #(.DATA_W(36)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0: 0x000000F30, 1: 0xFFFFFFFFF, 2: 0x123456789
  task automatic load_exp(input int id);
`ifdef PRODUCT_SERIALIZER_HEX_EN
    exp_n = 11;
    case (id)
      0: begin
        exp_b[0] = 8'h30; exp_b[1] = 8'h30; exp_b[2] = 8'h30; exp_b[3] = 8'h30;
        exp_b[4] = 8'h30; exp_b[5] = 8'h30; exp_b[6] = 8'h46; exp_b[7] = 8'h33;
        exp_b[8] = 8'h30;
      end
      1: for (int i = 0; i < 9; i++) exp_b[i] = 8'h46;
      default: for (int i = 0; i < 9; i++) exp_b[i] = 8'h31 + 8'(i);
    endcase
    exp_b[9]  = 8'h0D;
    exp_b[10] = 8'h0A;
`else
    exp_n = 5;
    case (id)
      0: begin
        exp_b[0] = 8'h30; exp_b[1] = 8'h0F; exp_b[2] = 8'h00;
        exp_b[3] = 8'h00; exp_b[4] = 8'h00;
      end
      1: begin
        exp_b[0] = 8'hFF; exp_b[1] = 8'hFF; exp_b[2] = 8'hFF;
        exp_b[3] = 8'hFF; exp_b[4] = 8'h0F;
      end
      default: begin
        exp_b[0] = 8'h89; exp_b[1] = 8'h67; exp_b[2] = 8'h45;
        exp_b[3] = 8'h23; exp_b[4] = 8'h01;
      end
    endcase
`endif
  endtask

  // pat 0: out_ready always high; pat 1: out_ready 1,0,0 repeating.
  // intrude: pulse in_valid with another word early in the frame.
  task automatic run_frame(input logic [35:0] word, input int pat, input bit intrude);
    int         got;
    int         cyc;
    bit         held_v;
    logic [7:0] held_d;
    check("pre_in_ready", {63'd0, in_ready}, 64'd1);
    in_data   = word;
    in_valid  = 1'b1;
    out_ready = (pat == 0);
    step();
    in_valid = 1'b0;
    got      = 0;
    cyc      = 0;
    held_v   = 1'b0;
    held_d   = 8'h00;
    while (got < exp_n && cyc < 200) begin
      out_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (intrude) begin
        in_valid = (cyc == 1) || (cyc == 2);
        in_data  = 36'h123456789;
      end
      check("frame_valid", {63'd0, out_valid}, 64'd1);
      check("frame_busy", {63'd0, busy}, 64'd1);
      check("frame_in_ready", {63'd0, in_ready}, 64'd0);
      if (held_v) check("stall_hold", {56'd0, out_data}, {56'd0, held_d});
      if (out_valid && out_ready) begin
        check("byte", {56'd0, out_data}, {56'd0, exp_b[got]});
        got++;
        held_v = 1'b0;
      end else begin
        held_v = out_valid;
        held_d = out_data;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("byte_count", 64'(got), 64'(exp_n));
    if (pat == 0) check("frame_cycles", 64'(cyc), 64'(exp_n));
    check("end_valid", {63'd0, out_valid}, 64'd0);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_data", {56'd0, out_data}, 64'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Full-rate frame, stalled frame, and a frame with an ignored intruder.
    load_exp(0);
    run_frame(36'h000000F30, 0, 1'b0);
    load_exp(1);
    run_frame(36'hFFFFFFFFF, 1, 1'b0);
    load_exp(0);
    run_frame(36'h000000F30, 0, 1'b1);
    load_exp(2);
    run_frame(36'h123456789, 1, 1'b0);

    // Reset after two transfers abandons the frame.
    load_exp(0);
    in_data   = 36'h000000F30;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_first_byte", {56'd0, out_data}, {56'd0, exp_b[0]});
    step();
    step();
    check("mid_third_byte", {56'd0, out_data}, {56'd0, exp_b[2]});
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_busy", {63'd0, busy}, 64'd0);
    check("async_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_residual", {63'd0, out_valid}, 64'd0);
    end

    // Back-to-back frames with in_valid held high.
    load_exp(0);
    in_data   = 36'h000000F30;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_data = 36'h123456789;
    for (int i = 0; i < exp_n; i++) begin
      check("b2b_f1_byte", {56'd0, out_data}, {56'd0, exp_b[i]});
      step();
    end
    check("b2b_gap_valid", {63'd0, out_valid}, 64'd0);
    check("b2b_gap_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    load_exp(2);
    check("b2b_f2_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_f2_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    for (int i = 0; i < exp_n; i++) begin
      check("b2b_f2_byte", {56'd0, out_data}, {56'd0, exp_b[i]});
      step();
    end
    check("b2b_end_valid", {63'd0, out_valid}, 64'd0);
    check("b2b_end_in_ready", {63'd0, in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/product_serializer.md
Name: product_serializer

Overview:
- Downstream stage of the registered a^5*b^4 product block.
- Accepts one 36-bit product word over a valid/ready handshake and emits it as a byte stream over a second valid/ready handshake.
- The byte stream feeds the board's byte-wide serial transmitter.
- A frame is fully drained before the next word is accepted.

Parameters:
- DATA_W, 36, width of the product word.
- NBYTES, (DATA_W+7)/8 = 5, raw-mode bytes per frame. Derived; do not override.

Ports:
- clk  input  1  system clock; all flops rise-edge triggered.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  product word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; out_valid=0, out_data=0x00, busy=0, byte counter=0, shift register=0.
  - in_ready is forced 0 while rst is low.
- in_ready = (state==IDLE) and rst high. It is combinational from state and not registered.
- Accept: in_valid && in_ready on a rising edge.
  - Capture in_data into the shift register, zero-padded to 8*NBYTES bits.
  - Clear the counter, go to SEND, set busy=1.
- in_valid while not IDLE is ignored. No queueing; upstream must hold or retry.
- SEND:
  - out_valid=1 from the cycle after accept; first-byte latency is 1 clock.
  - Raw order is LSB byte first.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Byte transfer on out_valid && out_ready:
  - Shift right 8 and increment the counter.
  - If the transferred byte was the last, go to IDLE with out_valid=0 and busy=0 on that edge.
- Back-to-back frames: in_ready rises in the cycle after the last transfer. The minimum gap between frames is 1 idle cycle, with no same-edge accept.
- out_ready held high means one byte per clock.
- out_ready is don't-care in IDLE.
- Reset mid-frame: the frame is abandoned immediately and no partial bytes are emitted after release.
- States: IDLE, SEND; TERM is present only with the optional feature.

Optional Feature:
- Macro: PRODUCT_SERIALIZER_HEX_EN.
- Defined:
  - Each frame is (DATA_W+3)/4 = 9 uppercase ASCII hex characters, MSB nibble first, leading zeros kept.
  - Then TERM emits 0x0D, 0x0A, for 11 bytes total.
  - Handshake rules are unchanged.
- Undefined:
  - Raw binary, NBYTES bytes, LSB first.
  - TERM state and ASCII logic are absent.

Decomposition:
- Package product_serializer_pkg holds:
  - state enum (IDLE, SEND, TERM);
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - function computing NBYTES and hex character count from DATA_W.
- One natural sub-module: nibble_to_ascii. It is combinational, 4-bit in, 8-bit out ('0'-'9', 'A'-'F'), and instantiated only under PRODUCT_SERIALIZER_HEX_EN.

Test Plan:
- Raw, out_ready=1, in_data=0x000000F30 (a=3, b=2): accept -> bytes 30,0F,00,00,00 on 5 consecutive cycles starting 1 cycle after accept. busy falls with the last byte; in_ready=1 the next cycle.
- Raw, in_data=0xFFFFFFFFF, out_ready toggling 1,0,0,1,...: bytes FF,FF,FF,FF,0F in order. out_data stays stable during each stall; no byte is duplicated or lost.
- Second in_valid pulse with in_data=0x123456789 during an active frame: ignored. The first frame completes unchanged and in_ready stays 0 throughout.
- rst pulled low after 2 of 5 bytes: out_valid=0 and busy=0 asynchronously. After release, in_ready=1 and no residual bytes appear.
- HEX_EN, in_data=0x000000F30: bytes "000000F30" then 0D, 0A (30,30,30,30,30,30,46,33,30,0D,0A), 11 transfers.
- Two frames back-to-back with in_valid held high: the second accept occurs exactly 1 cycle after the first frame's last transfer.
